counter_ctrl: RTL

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_pkg.sv | 15 +
 rtl/bcd_digit.sv | 45 ++++
 rtl/counter_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the BCD event counter: digit count, digit type, FSM states.
package counter_pkg;

    localparam int NDIG    = 4;
    localparam int BCD_MAX = 9;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter chain: holds a single digit 0..9, counts up or
// down when enabled and the lower decades hand it a carry/borrow.
module bcd_digit
    import counter_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clear,
    input  logic   en,
    input  logic   dir,
    input  logic   cin,
    output digit_t q,
    output logic   cout
);

    digit_t q_next;

    // Pass carry/borrow upward when this decade is about to roll over.
    assign cout = cin && (dir ? (q == digit_t'(0)) : (q == digit_t'(BCD_MAX)));

    // Next digit value; the up path treats anything >= 9 as 9 so the digit
    // can never settle outside 0..9.
    always_comb begin
        q_next = q;
        if (clear) begin
            q_next = digit_t'(0);
        end else if (en && cin) begin
            if (dir) begin
                q_next = (q == digit_t'(0)) ? digit_t'(BCD_MAX) : q - digit_t'(1);
            end else begin
                q_next = (q >= digit_t'(BCD_MAX)) ? digit_t'(0) : q + digit_t'(1);
            end
        end
    end

    // Digit register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= digit_t'(0);
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/clear BCD counter with prescaled tick, wrap pulse and
// leading-zero blanking for a multi-digit 7-segment display.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | stopped, count and prescaler at zero
// RUN   | prescaler running, count updates on tick
// PAUSE | stopped, count and prescaler held
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int DIV = 5_000_000
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  dir,
    output digit_t [NDIG-1:0]     digits,
    output logic   [NDIG-1:0]     blank,
    output logic                  running,
    output logic                  wrap
);

    localparam int             PW     = $clog2(DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic [NDIG:0]   carry;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides start_stop from every state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_stop) state_next = RUN;
            RUN:     if (start_stop) state_next = PAUSE;
            PAUSE:   if (start_stop) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // Outputs decoded straight from the registered state.
    always_comb begin
        running = (state == RUN);
        tick    = (state == RUN) && (prescaler == P_LAST);
    end

    // Prescaler advances every RUN cycle, holds otherwise, zeroed by clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (state == RUN) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    // Digit chain: decade 0 always sees a carry-in, each tick ripples upward.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .en    (tick),
            .dir   (dir),
            .cin   (carry[g]),
            .q     (digits[g]),
            .cout  (carry[g+1])
        );
    end

    // Wrap pulse: the tick rolled the whole chain over (9999->0000 or 0000->9999).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tick && !clear && carry[NDIG];
        end
    end

    // Leading-zero blanking; the least significant digit is always shown.
    always_comb begin
        logic zero_hi;
        blank   = '0;
        zero_hi = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_hi  = zero_hi && (digits[i] == digit_t'(0));
            blank[i] = zero_hi;
        end
    end

endmodule
